decode_stage: RTL and testbench
===============================

# decode_stage

Parametrised, pipelined successor to the accumulator-machine instruction decoder. It sits between instruction fetch and the datapath. It accepts one instruction per cycle over a valid/ready handshake, supports NACC accumulators, and registers a decoded control bundle. Conditional branches stall until every in-flight write to their accumulator has retired. After a taken jump or branch, it discards FLUSH_N wrong-path instructions.

## Interface
- IW, 18: instruction width
- OPW, 6: opcode width, field in[IW-1:IW-OPW]
- NACC, 4: accumulator count (2..4); ACCW = clog2(NACC), minimum 1; accumulator field in[AW+ACCW-1:AW]
- AW, 10: memory/jump address width, field in[AW-1:0]
- DW, 8: immediate width, field in[DW-1:0]
- BRW, 6: branch offset width, field in[BRW-1:0]
- PCW, 2: width of each pending-write counter
- FLUSH_N, 1: instructions discarded after a taken transfer (0..3)
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- in_instr  in  IW  instruction word
- in_valid / in_ready  in / out  1  fetch handshake
- flags  in  3*NACC  per-accumulator {z,c,n}; accumulator i occupies [3i+2:3i]
- wb_done  in  NACC  one-cycle pulse per retired accumulator write
- out_valid / out_ready  out / in  1  datapath handshake
- op_class  out  3, alu_fn  out  3, acc_sel  out  ACCW
- acc_we, wr_enable, src_const, jmp_enable, branch_enable  out  1 each
- imm  out  DW, mem_addr  out  AW, branch_off  out  BRW
- err_underflow  out  1  sticky: wb_done seen while that counter was 0

## Operation
- Opcode class is opcode[5:3]; sub-field is opcode[2:0].
  - 000 NOP.
  - 001 LD mem: acc_we.
  - 010 LD const: acc_we, src_const.
  - 011 ST: wr_enable.
  - 100 ALU mem: acc_we.
  - 101 ALU const: acc_we, src_const.
  - 110 JMP: jmp_enable.
  - 111 BRANCH.
- ALU fn (sub-field): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ASL, 5 ASR.
- Branch cond (sub-field): 0 EQ (z=1), 1 NE (z=0), 2 CS (c=1), 3 CC (c=0), 4 MI (n=1), 5 PL (n=0), tested on flags of acc_sel.
- Sub-field 6 or 7 in classes 100, 101 or 111: emitted with all enables 0 (NOP behaviour). out_valid is still asserted.
- Writers are classes 001, 010, 100 and 101.
  - Accepting a writer increments pending[acc].
  - wb_done[i] decrements pending[i].
  - Both in the same cycle: counter unchanged.
  - wb_done[i] while pending[i]=0: counter stays 0 and err_underflow is set.
- States are ACCEPT, BR_WAIT and FLUSH.
- ACCEPT:
  - in_ready = (!out_valid | out_ready) & !(incoming writer with pending[acc] = 2^PCW-1).
  - A branch accepted while pending[acc]=0 resolves immediately against the current flags.
  - A branch accepted while pending[acc]!=0 is stored in the hold register; go to BR_WAIT.
- BR_WAIT:
  - in_ready=0.
  - When registered pending[acc]=0 and the output slot is free: emit the branch, resolved on the current flags.
- After emitting JMP or a taken branch:
  - FLUSH_N>0: go to FLUSH with the counter set to FLUSH_N.
  - Otherwise: stay in or return to ACCEPT.
- FLUSH:
  - in_ready=1.
  - Each accepted word is dropped: no output, no counter update.
  - Leave for ACCEPT when the counter reaches 0.
- Not-taken branch: emitted with branch_enable=0; no flush.
- Output fields (imm, mem_addr, branch_off) are straight slices of the accepted word, registered with the bundle.

## Timing
- Reset (reset=0 at posedge): state ACCEPT. All outputs are 0 except in_ready=1. Pending counters, flush counter, hold register and err_underflow are cleared. Reset in BR_WAIT or FLUSH abandons the held or flushing instruction.
- Latency: an instruction accepted at edge k appears with out_valid=1 after edge k.
- The output holds its value while out_valid & !out_ready. No combinational path from in_valid to outputs.
- in_ready depends on out_ready combinationally (pass-through when the slot drains).
- BR_WAIT exit: emitted on the edge after the cycle where registered pending reads 0. A wb_done arriving in the final cycle costs one extra cycle.
- Full throughput: 1 instruction per cycle when out_ready=1 and there are no hazards.

## Test plan
- Reset and stream: NOP, LD const acc1 imm 0x5A, ST addr 0x3FF, each with out_ready=1. Outputs appear 1 cycle after each; src_const=1 / imm=0x5A; wr_enable=1 / mem_addr=0x3FF; pending[1]=1.
- Backpressure: out_ready=0 for 3 cycles with 2 instructions offered. First bundle is held stable; in_ready=0; second is emitted the cycle after out_ready=1.
- Branch stall:
  - ALU acc2 accepted, then BEQ acc2.
  - State stays BR_WAIT until wb_done[2].
  - With flags z=1: branch_enable=1 on the edge after the counter reads 0.
  - The next fetched word is dropped (FLUSH_N=1).
- Not-taken branch: BNE acc0 with z=1 and pending 0. branch_enable=0; the following instruction is emitted with no flush.
- Saturation and underflow:
  - Four writers to acc3 (PCW=2): in_ready drops on the 4th.
  - wb_done[3] re-enables it.
  - wb_done[0] with pending 0: err_underflow=1, sticky.
- Reset in BR_WAIT: reset=0 for 1 cycle. State returns to ACCEPT, counters are 0, and no branch is emitted.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: pipelined accumulator-machine instruction decoder.
// Ports: fetch handshake (in_instr/in_valid/in_ready), datapath status
// (flags, wb_done), registered control bundle (out_valid/out_ready,
// op_class, alu_fn, acc_sel, enables, imm, mem_addr, branch_off) and
// the sticky err_underflow flag.
module decode_stage #(
   parameter int IW      = 18,
   parameter int OPW     = 6,
   parameter int NACC    = 4,
   parameter int AW      = 10,
   parameter int DW      = 8,
   parameter int BRW     = 6,
   parameter int PCW     = 2,
   parameter int FLUSH_N = 1,
   localparam int ACCW   = (NACC > 2) ? $clog2(NACC) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IW-1:0]     in_instr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3*NACC-1:0] flags,
   input  logic [NACC-1:0]   wb_done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        op_class,
   output logic [2:0]        alu_fn,
   output logic [ACCW-1:0]   acc_sel,
   output logic              acc_we,
   output logic              wr_enable,
   output logic              src_const,
   output logic              jmp_enable,
   output logic              branch_enable,
   output logic [DW-1:0]     imm,
   output logic [AW-1:0]     mem_addr,
   output logic [BRW-1:0]    branch_off,
   output logic              err_underflow
);

   typedef enum logic [1:0] {S_ACCEPT, S_BR_WAIT, S_FLUSH} state_t;

   typedef struct packed {
      logic            valid;
      logic [2:0]      op_class;
      logic [2:0]      alu_fn;
      logic [ACCW-1:0] acc_sel;
      logic            acc_we;
      logic            wr_enable;
      logic            src_const;
      logic            jmp_enable;
      logic            branch_enable;
      logic [DW-1:0]   imm;
      logic [AW-1:0]   mem_addr;
      logic [BRW-1:0]  branch_off;
   } bundle_t;

   function automatic bundle_t decode(input logic [IW-1:0] w,
                                      input logic [3*NACC-1:0] f);
      bundle_t    b;
      logic [2:0] cls;
      logic [2:0] sub;
      logic [2:0] fl;
      logic       ok;
      b          = '0;
      cls        = w[IW-1 -: 3];
      sub        = w[IW-OPW +: 3];
      ok         = (sub < 3'd6);
      b.valid    = 1'b1;
      b.op_class = cls;
      b.acc_sel  = w[AW +: ACCW];
      b.imm      = w[DW-1:0];
      b.mem_addr = w[AW-1:0];
      b.branch_off = w[BRW-1:0];
      // {z,c,n} of the addressed accumulator
      fl = 3'(f >> (3 * int'(b.acc_sel)));
      unique case (cls)
         3'b001: b.acc_we = 1'b1;
         3'b010: begin
            b.acc_we    = 1'b1;
            b.src_const = 1'b1;
         end
         3'b011: b.wr_enable = 1'b1;
         3'b100: if (ok) begin
            b.acc_we = 1'b1;
            b.alu_fn = sub;
         end
         3'b101: if (ok) begin
            b.acc_we    = 1'b1;
            b.src_const = 1'b1;
            b.alu_fn    = sub;
         end
         3'b110: b.jmp_enable = 1'b1;
         3'b111: begin
            case (sub)
               3'd0:    b.branch_enable = fl[2];
               3'd1:    b.branch_enable = !fl[2];
               3'd2:    b.branch_enable = fl[1];
               3'd3:    b.branch_enable = !fl[1];
               3'd4:    b.branch_enable = fl[0];
               3'd5:    b.branch_enable = !fl[0];
               default: b.branch_enable = 1'b0;
            endcase
         end
         default: ;
      endcase
      return b;
   endfunction

   state_t                    state_q, state_d;
   bundle_t                   bnd_q, bnd_d;
   logic [IW-1:0]             hold_q, hold_d;
   logic [1:0]                fcnt_q, fcnt_d;
   logic [NACC-1:0][PCW-1:0]  pend_q, pend_d;
   logic                      err_q, err_d;

   bundle_t         in_dec;
   bundle_t         hold_dec;
   logic [ACCW-1:0] in_acc;
   logic [ACCW-1:0] hold_acc;
   logic            in_is_br;
   logic            slot_free;
   logic            in_sat;
   logic            accept;
   logic            xfer;
   logic [NACC-1:0] inc;

   assign in_dec    = decode(in_instr, flags);
   assign hold_dec  = decode(hold_q, flags);
   assign in_acc    = in_instr[AW +: ACCW];
   assign hold_acc  = hold_q[AW +: ACCW];
   assign in_is_br  = (in_instr[IW-1 -: 3] == 3'b111)
                    & (in_instr[IW-OPW +: 3] < 3'd6);
   assign slot_free = !bnd_q.valid | out_ready;
   // a writer whose counter is already full must wait for a retire
   assign in_sat    = in_dec.acc_we & (pend_q[in_acc] == '1);
   assign accept    = in_valid & in_ready;

   always_comb begin
      in_ready = 1'b0;
      unique case (state_q)
         S_ACCEPT:  in_ready = slot_free & !in_sat;
         S_BR_WAIT: in_ready = 1'b0;
         S_FLUSH:   in_ready = 1'b1;
         default:   in_ready = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      bnd_d   = bnd_q;
      hold_d  = hold_q;
      fcnt_d  = fcnt_q;
      inc     = '0;
      xfer    = 1'b0;
      if (slot_free) bnd_d.valid = 1'b0;
      unique case (state_q)
         S_ACCEPT: if (accept) begin
            if (in_is_br && pend_q[in_acc] != '0) begin
               hold_d  = in_instr;
               state_d = S_BR_WAIT;
            end else begin
               bnd_d = in_dec;
               xfer  = in_dec.jmp_enable | in_dec.branch_enable;
            end
            if (in_dec.acc_we) inc[in_acc] = 1'b1;
         end
         S_BR_WAIT: if (pend_q[hold_acc] == '0 && slot_free) begin
            bnd_d   = hold_dec;
            xfer    = hold_dec.branch_enable;
            state_d = S_ACCEPT;
         end
         S_FLUSH: if (accept) begin
            fcnt_d = fcnt_q - 2'd1;
            if (fcnt_q == 2'd1) state_d = S_ACCEPT;
         end
         default: state_d = S_ACCEPT;
      endcase
      if (xfer && FLUSH_N > 0) begin
         state_d = S_FLUSH;
         fcnt_d  = 2'(FLUSH_N);
      end
   end

   always_comb begin
      pend_d = pend_q;
      err_d  = err_q;
      for (int i = 0; i < NACC; i++) begin
         if (inc[i] && !wb_done[i]) begin
            pend_d[i] = pend_q[i] + PCW'(1);
         end else if (!inc[i] && wb_done[i]) begin
            if (pend_q[i] == '0) err_d = 1'b1;
            else pend_d[i] = pend_q[i] - PCW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_ACCEPT;
         bnd_q   <= '0;
         hold_q  <= '0;
         fcnt_q  <= '0;
         pend_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bnd_q   <= bnd_d;
         hold_q  <= hold_d;
         fcnt_q  <= fcnt_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
      end
   end

   assign out_valid     = bnd_q.valid;
   assign op_class      = bnd_q.op_class;
   assign alu_fn        = bnd_q.alu_fn;
   assign acc_sel       = bnd_q.acc_sel;
   assign acc_we        = bnd_q.acc_we;
   assign wr_enable     = bnd_q.wr_enable;
   assign src_const     = bnd_q.src_const;
   assign jmp_enable    = bnd_q.jmp_enable;
   assign branch_enable = bnd_q.branch_enable;
   assign imm           = bnd_q.imm;
   assign mem_addr      = bnd_q.mem_addr;
   assign branch_off    = bnd_q.branch_off;
   assign err_underflow = err_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed steps plus a randomized stream for decode_stage.
// Expected bundles come from a rule-level model kept in this file.
module tb_decode_stage;

   logic        clk;
   logic        reset;
   logic [17:0] in_instr;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] flags;
   logic [3:0]  wb_done;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  op_class;
   logic [2:0]  alu_fn;
   logic [1:0]  acc_sel;
   logic        acc_we, wr_enable, src_const, jmp_enable, branch_enable;
   logic [7:0]  imm;
   logic [9:0]  mem_addr;
   logic [5:0]  branch_off;
   logic        err_underflow;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [2:0] cls;
      logic [2:0] fn;
      logic [1:0] acc;
      logic       we;
      logic       wr;
      logic       sc;
      logic       jp;
      logic       br;
      logic [7:0] imm;
      logic [9:0] mem;
      logic [5:0] off;
   } exp_t;

   decode_stage dut (
      .clk(clk), .reset(reset),
      .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
      .flags(flags), .wb_done(wb_done),
      .out_valid(out_valid), .out_ready(out_ready),
      .op_class(op_class), .alu_fn(alu_fn), .acc_sel(acc_sel),
      .acc_we(acc_we), .wr_enable(wr_enable), .src_const(src_const),
      .jmp_enable(jmp_enable), .branch_enable(branch_enable),
      .imm(imm), .mem_addr(mem_addr), .branch_off(branch_off),
      .err_underflow(err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [17:0] mk(int c, int s, int a, int low);
      return {3'(c), 3'(s), 2'(a), 10'(low)};
   endfunction

   // Reference: the control bundle an instruction word should produce.
   function automatic exp_t model(input logic [17:0] w, input logic [11:0] f);
      exp_t       e;
      int         c, s, a;
      logic [2:0] fl;
      bit         alu_ok;
      c      = int'(w[17:15]);
      s      = int'(w[14:12]);
      a      = int'(w[11:10]);
      fl     = 3'(f >> (3 * a));
      alu_ok = (c == 4 || c == 5) && s < 6;
      e      = '0;
      e.cls  = 3'(c);
      e.acc  = 2'(a);
      e.we   = (c == 1 || c == 2 || alu_ok);
      e.sc   = (c == 2) || (c == 5 && alu_ok);
      e.wr   = (c == 3);
      e.jp   = (c == 6);
      e.fn   = alu_ok ? 3'(s) : 3'd0;
      // pairs of conditions test z, c, n; the odd member negates
      if (c == 7 && s < 6) e.br = fl[2 - s / 2] ^ (s % 2 == 1);
      e.imm  = w[7:0];
      e.mem  = w[9:0];
      e.off  = w[5:0];
      return e;
   endfunction

   function automatic exp_t observed();
      return {op_class, alu_fn, acc_sel, acc_we, wr_enable, src_const,
              jmp_enable, branch_enable, imm, mem_addr, branch_off};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive(input logic v, input logic [17:0] w);
      in_valid = v;
      in_instr = w;
   endtask

   task automatic expect_out(input string tag, input logic [17:0] w);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk(tag, 64'(observed()), 64'(model(w, flags)));
   endtask

   logic [17:0] wa, wb, wx;
   exp_t        q[$];
   int          pend[4];
   int          fl_left;
   exp_t        e;

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_instr = '0;
      out_ready = 1'b1; flags = '0; wb_done = '0;
      tick(); tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_bundle", 64'(observed()), 64'd0);
      chk("rst_err", 64'(err_underflow), 64'd0);
      reset = 1'b1;
      settle();
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // stream
      drive(1, mk(0, 0, 0, 0));
      tick();
      expect_out("nop", mk(0, 0, 0, 0));
      drive(1, mk(2, 0, 1, 'h05A));
      tick();
      expect_out("ldc", mk(2, 0, 1, 'h05A));
      chk("ldc_src_const", 64'(src_const), 64'd1);
      chk("ldc_imm", 64'(imm), 64'h5A);
      drive(1, mk(3, 0, 0, 'h3FF));
      tick();
      expect_out("st", mk(3, 0, 0, 'h3FF));
      chk("st_addr", 64'(mem_addr), 64'h3FF);
      drive(0, '0);
      wb_done = 4'b0010;
      tick();
      wb_done = '0;
      chk("pend1_retire", 64'(err_underflow), 64'd0);

      // backpressure
      wa = mk(3, 0, 2, 'h155);
      wb = mk(3, 0, 1, 'h0AA);
      out_ready = 1'b0;
      drive(1, wa);
      settle();
      chk("bp_ready_empty", 64'(in_ready), 64'd1);
      tick();
      drive(1, wb);
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         expect_out("bp_hold", wa);
         tick();
      end
      out_ready = 1'b1;
      settle();
      chk("bp_passthru", 64'(in_ready), 64'd1);
      tick();
      expect_out("bp_second", wb);
      drive(0, '0);
      tick();
      chk("bp_drained", 64'(out_valid), 64'd0);

      // branch stall on acc2, z=1, then one word flushed
      flags = 12'h100;
      drive(1, mk(4, 0, 2, 'h033));
      tick();
      expect_out("alu_acc2", mk(4, 0, 2, 'h033));
      drive(1, mk(7, 0, 2, 'h015));
      tick();
      chk("brw_no_out", 64'(out_valid), 64'd0);
      wx = mk(3, 0, 0, 'h111);
      drive(1, wx);
      settle();
      chk("brw_in_ready", 64'(in_ready), 64'd0);
      tick();
      chk("brw_wait1", 64'(out_valid), 64'd0);
      tick();
      chk("brw_wait2", 64'(out_valid), 64'd0);
      wb_done = 4'b0100;
      tick();
      wb_done = '0;
      chk("brw_retire_cycle", 64'(out_valid), 64'd0);
      tick();
      expect_out("beq_emit", mk(7, 0, 2, 'h015));
      chk("beq_taken", 64'(branch_enable), 64'd1);
      settle();
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      tick();
      chk("flush_dropped", 64'(out_valid), 64'd0);
      drive(1, mk(3, 0, 3, 'h222));
      tick();
      expect_out("after_flush", mk(3, 0, 3, 'h222));

      // not-taken branch
      flags = 12'h004;
      drive(1, mk(7, 1, 0, 'h02A));
      tick();
      expect_out("bne", mk(7, 1, 0, 'h02A));
      chk("bne_not_taken", 64'(branch_enable), 64'd0);
      drive(1, mk(3, 0, 1, 'h0F0));
      tick();
      expect_out("bne_next", mk(3, 0, 1, 'h0F0));
      drive(0, '0);
      tick();

      // saturation of acc3
      for (int k = 0; k < 3; k++) begin
         drive(1, mk(1, 0, 3, 'h100 + k));
         settle();
         chk("sat_ready", 64'(in_ready), 64'd1);
         tick();
      end
      drive(1, mk(1, 0, 3, 'h103));
      settle();
      chk("sat_block", 64'(in_ready), 64'd0);
      tick();
      wb_done = 4'b1000;
      settle();
      chk("sat_block_retire", 64'(in_ready), 64'd0);
      tick();
      wb_done = '0;
      settle();
      chk("sat_release", 64'(in_ready), 64'd1);
      tick();
      expect_out("sat_fourth", mk(1, 0, 3, 'h103));
      drive(0, '0);

      // underflow
      wb_done = 4'b0001;
      tick();
      wb_done = '0;
      chk("underflow", 64'(err_underflow), 64'd1);
      tick();
      chk("underflow_sticky", 64'(err_underflow), 64'd1);

      // reset while holding a branch
      flags = 12'h200;
      drive(1, mk(7, 4, 3, 'h007));
      tick();
      chk("brw3_no_out", 64'(out_valid), 64'd0);
      drive(0, '0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      settle();
      chk("rst2_out_valid", 64'(out_valid), 64'd0);
      chk("rst2_err", 64'(err_underflow), 64'd0);
      chk("rst2_in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst2_no_branch", 64'(out_valid), 64'd0);
      end
      wb_done = 4'b1000;
      tick();
      wb_done = '0;
      chk("rst2_pend_cleared", 64'(err_underflow), 64'd1);

      // randomized stream against the model
      reset = 1'b0;
      tick();
      reset = 1'b1;
      flags = 12'($urandom);
      foreach (pend[i]) pend[i] = 0;
      fl_left = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_instr  = 18'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 4; i++)
            wb_done[i] = (pend[i] > 0) && ($urandom_range(0, 2) == 0);
         settle();
         e = model(in_instr, flags);
         if (fl_left == 0 && in_valid && e.we && pend[e.acc] == 3)
            chk("rand_sat", 64'(in_ready), 64'd0);
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("rand_unexpected", 64'd1, 64'd0);
            else chk("rand_out", 64'(observed()), 64'(q.pop_front()));
         end
         if (in_valid && in_ready) begin
            if (fl_left > 0) begin
               fl_left--;
            end else begin
               q.push_back(e);
               if (e.we) pend[e.acc]++;
               if (e.jp || e.br) fl_left = 1;
            end
         end
         for (int i = 0; i < 4; i++) if (wb_done[i]) pend[i]--;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         for (int i = 0; i < 4; i++) wb_done[i] = (pend[i] > 0);
         settle();
         if (out_valid) begin
            if (q.size() == 0) chk("drain_unexpected", 64'd1, 64'd0);
            else chk("drain_out", 64'(observed()), 64'(q.pop_front()));
         end
         for (int i = 0; i < 4; i++) if (wb_done[i]) pend[i]--;
         tick();
      end
      wb_done = '0;
      chk("drain_empty", 64'(q.size()), 64'd0);
      chk("rand_no_underflow", 64'(err_underflow), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
